// File: rtl/miner_cmd_frontend.sv
// miner_cmd_frontend: SPI byte command decoder that assembles hash jobs, reads them back and returns results.
// Optional build macro MINER_CMD_CHECKSUM_EN: LOAD expects a trailing XOR checksum byte before committing.
module miner_cmd_frontend #(
  parameter int STATE_BYTES = 32,
  parameter int MSG_BYTES   = 12,
  parameter int RES_BYTES   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic [7:0]               tx_data,
  output logic [STATE_BYTES*8-1:0] job_state,
  output logic [MSG_BYTES*8-1:0]   job_msg,
  output logic                     job_valid,
  input  logic                     job_ready,
  input  logic                     core_busy,
  input  logic                     res_valid,
  input  logic [RES_BYTES*8-1:0]   res_data,
  output logic                     err_flag
);

  localparam int JOB_BYTES = STATE_BYTES + MSG_BYTES;
  localparam int JOB_W     = JOB_BYTES * 8;
  localparam int RES_W     = RES_BYTES * 8;
  localparam int CNT_W     = ($clog2(JOB_BYTES + 1) > $clog2(RES_BYTES + 1)) ?
                             $clog2(JOB_BYTES + 1) : $clog2(RES_BYTES + 1);

  localparam logic [CNT_W-1:0] JOB_LAST = CNT_W'(JOB_BYTES - 1);
  localparam logic [CNT_W-1:0] RES_LAST = CNT_W'(RES_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

`ifdef MINER_CMD_CHECKSUM_EN
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(JOB_BYTES);
  localparam int               SHADOW_W  = JOB_W;
`else
  localparam logic [CNT_W-1:0] LOAD_LAST = JOB_LAST;
  localparam int               SHADOW_W  = JOB_W - 8;
`endif

  localparam logic [7:0] CMD_MSG_START = 8'hA2;
  localparam logic [7:0] CMD_GET_STATE = 8'hA3;
  localparam logic [7:0] CMD_GET_MSG   = 8'hA4;
  localparam logic [7:0] CMD_GET_RES   = 8'hA5;
  localparam logic [7:0] STS_WAITING   = 8'hA0;
  localparam logic [7:0] STS_WORKING   = 8'hA1;
  localparam logic [7:0] STS_RES_READY = 8'hA6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RD_JOB = 2'd2,
    ST_RD_RES = 2'd3
  } state_t;

`ifdef MINER_CMD_CHECKSUM_EN
  function automatic logic [7:0] xor_bytes(input logic [JOB_W-1:0] data);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < JOB_BYTES; i++) begin
      acc = acc ^ data[i*8 +: 8];
    end
    return acc;
  endfunction
`endif

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [SHADOW_W-1:0] shadow_r;
  logic [RES_W-1:0]    res_buf_r;
  logic                res_pending_r;
  logic                hold_r;
  logic [RES_W-1:0]    hold_data_r;

  logic [CNT_W-1:0]    rd_idx_s;
  logic [CNT_W-1:0]    job_sh_s;
  logic [CNT_W-1:0]    res_sh_s;
  logic [JOB_W-1:0]    job_all_s;
  logic [7:0]          job_byte_s;
  logic [7:0]          res_byte_s;
  logic [7:0]          status_s;
  logic [SHADOW_W-1:0] shadow_next_s;
  logic [JOB_W-1:0]    commit_data_s;
  logic                load_done_s;
  logic                commit_s;
  logic                csum_err_s;
  logic                rd_res_done_s;

  // Readback byte selection and status byte; indexes the job/result without disturbing them.
  always_comb begin
    if (state_r == ST_IDLE) begin
      rd_idx_s = CNT_ZERO;
    end else begin
      rd_idx_s = cnt_r + CNT_ONE;
    end
    job_all_s  = {job_state, job_msg};
    job_sh_s   = JOB_LAST - rd_idx_s;
    res_sh_s   = RES_LAST - rd_idx_s;
    job_byte_s = 8'(job_all_s >> {job_sh_s, 3'b000});
    res_byte_s = 8'(res_buf_r >> {res_sh_s, 3'b000});
    if (res_pending_r) begin
      status_s = STS_RES_READY;
    end else if (core_busy) begin
      status_s = STS_WORKING;
    end else begin
      status_s = STS_WAITING;
    end
  end

  // Load completion and the value handed to the job registers.
  always_comb begin
    shadow_next_s = SHADOW_W'({shadow_r, rx_data});
    load_done_s   = rx_valid && (state_r == ST_LOAD) && (cnt_r == LOAD_LAST);
    rd_res_done_s = rx_valid && (state_r == ST_RD_RES) && (cnt_r == RES_LAST);
`ifdef MINER_CMD_CHECKSUM_EN
    commit_data_s = shadow_r;
    commit_s      = load_done_s && (xor_bytes(shadow_r) == rx_data);
    csum_err_s    = load_done_s && (xor_bytes(shadow_r) != rx_data);
`else
    commit_data_s = {shadow_r, rx_data};
    commit_s      = load_done_s;
    csum_err_s    = 1'b0;
`endif
  end

  // Command FSM: decodes bytes, fills the shadow buffer and walks readback pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      tx_data  <= STS_WAITING;
      shadow_r <= {SHADOW_W{1'b0}};
      err_flag <= 1'b0;
    end else if (rx_valid) begin
      case (state_r)
        ST_IDLE: begin
          case (rx_data)
            CMD_MSG_START: begin
              state_r <= ST_LOAD;
              cnt_r   <= CNT_ZERO;
            end
            CMD_GET_STATE: begin
              tx_data <= status_s;
            end
            CMD_GET_MSG: begin
              state_r <= ST_RD_JOB;
              cnt_r   <= CNT_ZERO;
              tx_data <= job_byte_s;
            end
            CMD_GET_RES: begin
              state_r <= ST_RD_RES;
              cnt_r   <= CNT_ZERO;
              tx_data <= res_byte_s;
            end
            default: begin
              err_flag <= 1'b1;
              tx_data  <= STS_WAITING;
            end
          endcase
        end
        ST_LOAD: begin
          shadow_r <= shadow_next_s;
          if (cnt_r == LOAD_LAST) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            tx_data <= STS_WAITING;
            if (csum_err_s) begin
              err_flag <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_RD_JOB: begin
          if (cnt_r == JOB_LAST) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            tx_data <= STS_WAITING;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
            tx_data <= job_byte_s;
          end
        end
        ST_RD_RES: begin
          if (cnt_r == RES_LAST) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            tx_data <= STS_WAITING;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
            tx_data <= res_byte_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
          tx_data <= STS_WAITING;
        end
      endcase
    end
  end

  // Job hand-off: a completing load always wins over acceptance in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      job_state <= {(STATE_BYTES*8){1'b0}};
      job_msg   <= {(MSG_BYTES*8){1'b0}};
      job_valid <= 1'b0;
    end else if (commit_s) begin
      {job_state, job_msg} <= commit_data_s;
      job_valid            <= 1'b1;
    end else if (job_valid && job_ready) begin
      job_valid <= 1'b0;
    end
  end

  // Result capture; a result arriving mid-readback is parked until the readback ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_buf_r     <= {RES_W{1'b0}};
      res_pending_r <= 1'b0;
      hold_r        <= 1'b0;
      hold_data_r   <= {RES_W{1'b0}};
    end else if (state_r == ST_RD_RES) begin
      if (rd_res_done_s) begin
        hold_r <= 1'b0;
        if (res_valid) begin
          res_buf_r     <= res_data;
          res_pending_r <= 1'b1;
        end else if (hold_r) begin
          res_buf_r     <= hold_data_r;
          res_pending_r <= 1'b1;
        end else begin
          res_pending_r <= 1'b0;
        end
      end else if (res_valid) begin
        hold_r      <= 1'b1;
        hold_data_r <= res_data;
      end
    end else if (res_valid) begin
      res_buf_r     <= res_data;
      res_pending_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_miner_cmd_frontend.sv
// Self-checking bench for miner_cmd_frontend: byte-queue reference model compared every cycle,
// plus literal expectations for the documented command sequences.
module tb_miner_cmd_frontend;

  localparam int SB  = 32;
  localparam int MB  = 12;
  localparam int RB  = 4;
  localparam int JOB = SB + MB;
`ifdef MINER_CMD_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RDJ  = 2;
  localparam int M_RDR  = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            rx_valid = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic [7:0]      tx_data;
  logic [SB*8-1:0] job_state;
  logic [MB*8-1:0] job_msg;
  logic            job_valid;
  logic            job_ready = 1'b0;
  logic            core_busy = 1'b0;
  logic            res_valid = 1'b0;
  logic [RB*8-1:0] res_data = '0;
  logic            err_flag;

  miner_cmd_frontend #(.STATE_BYTES(SB), .MSG_BYTES(MB), .RES_BYTES(RB)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .tx_data(tx_data),
    .job_state(job_state), .job_msg(job_msg), .job_valid(job_valid), .job_ready(job_ready),
    .core_busy(core_busy), .res_valid(res_valid), .res_data(res_data), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_on = 1'b0;

  // Reference model state: plain byte arrays and a queue for the bytes being loaded.
  logic [7:0] m_job[JOB];
  logic [7:0] m_res[RB];
  logic [7:0] m_shadow[$];
  logic [RB*8-1:0] m_hold_d;
  bit         m_hold_v, m_valid, m_err, m_pend;
  logic [7:0] m_tx;
  int         m_mode, m_sent;

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_tx = 8'hA0; m_valid = 0; m_err = 0; m_pend = 0; m_hold_v = 0; m_hold_d = '0;
    m_mode = M_IDLE; m_sent = 0; m_shadow.delete();
    for (int i = 0; i < JOB; i++) m_job[i] = 8'h00;
    for (int i = 0; i < RB; i++) m_res[i] = 8'h00;
  endtask

  task automatic model_set_res(input logic [RB*8-1:0] v);
    for (int i = 0; i < RB; i++) m_res[i] = v[(RB-1-i)*8 +: 8];
    m_pend = 1;
  endtask

  task automatic model_step();
    int mode0;
    bit res_exit, commit;
    logic [7:0] x;
    mode0 = m_mode; res_exit = 0; commit = 0;
    if (rx_valid) begin
      case (m_mode)
        M_IDLE: begin
          case (rx_data)
            8'hA2: begin m_mode = M_LOAD; m_shadow.delete(); end
            8'hA3: m_tx = m_pend ? 8'hA6 : (core_busy ? 8'hA1 : 8'hA0);
            8'hA4: begin m_mode = M_RDJ; m_tx = m_job[0]; m_sent = 1; end
            8'hA5: begin m_mode = M_RDR; m_tx = m_res[0]; m_sent = 1; end
            default: begin m_err = 1; m_tx = 8'hA0; end
          endcase
        end
        M_LOAD: begin
          m_shadow.push_back(rx_data);
          if (m_shadow.size() == JOB + CS) begin
            m_mode = M_IDLE; m_tx = 8'hA0;
            x = 8'h00;
            for (int i = 0; i < JOB; i++) x = x ^ m_shadow[i];
            if (CS == 0 || x == m_shadow[JOB]) commit = 1;
            else m_err = 1;
          end
        end
        M_RDJ: begin
          if (m_sent == JOB) begin m_tx = 8'hA0; m_mode = M_IDLE; end
          else begin m_tx = m_job[m_sent]; m_sent++; end
        end
        default: begin
          if (m_sent == RB) begin m_tx = 8'hA0; m_mode = M_IDLE; res_exit = 1; end
          else begin m_tx = m_res[m_sent]; m_sent++; end
        end
      endcase
    end
    if (commit) begin
      for (int i = 0; i < JOB; i++) m_job[i] = m_shadow[i];
      m_valid = 1;
    end else if (m_valid && job_ready) begin
      m_valid = 0;
    end
    if (mode0 == M_RDR && !res_exit) begin
      if (res_valid) begin m_hold_v = 1; m_hold_d = res_data; end
    end else if (mode0 == M_RDR) begin
      m_pend = 0;
      if (res_valid) model_set_res(res_data);
      else if (m_hold_v) model_set_res(m_hold_d);
      m_hold_v = 0;
    end else if (res_valid) begin
      model_set_res(res_data);
    end
  endtask

  function automatic logic [SB*8-1:0] exp_state();
    logic [SB*8-1:0] v;
    for (int i = 0; i < SB; i++) v[(SB-1-i)*8 +: 8] = m_job[i];
    return v;
  endfunction

  function automatic logic [MB*8-1:0] exp_msg();
    logic [MB*8-1:0] v;
    for (int i = 0; i < MB; i++) v[(MB-1-i)*8 +: 8] = m_job[SB+i];
    return v;
  endfunction

  // Single compare process: every falling edge outside reset, DUT outputs vs model.
  always @(negedge clk) begin
    if (!reset && model_on) begin
      check("cyc_tx_data", 384'(tx_data), 384'(m_tx));
      check("cyc_job_valid", 384'(job_valid), 384'(m_valid));
      check("cyc_err_flag", 384'(err_flag), 384'(m_err));
      check("cyc_job_state", 384'(job_state), 384'(exp_state()));
      check("cyc_job_msg", 384'(job_msg), 384'(exp_msg()));
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) begin @(posedge clk); #2; end
    reset = 1'b0;
    step();
  endtask

  // Sends MSG_START, JOB bytes base+i (plus checksum when enabled); job_ready optionally on the final byte.
  task automatic load_job(input logic [7:0] base, input bit ready_last);
    logic [7:0] q[$];
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < JOB; i++) begin q.push_back(8'(base + i)); x = x ^ 8'(base + i); end
    if (CS == 1) q.push_back(x);
    send(8'hA2);
    for (int i = 0; i < q.size(); i++) begin
      if (ready_last && i == q.size() - 1) job_ready = 1'b1;
      send(q[i]);
      job_ready = 1'b0;
    end
  endtask

  logic [7:0]      b8;
  logic [MB*8-1:0] msg_lit;

  initial begin
    model_reset();
    model_on = 1'b1;
    apply_reset();
    check("reset_tx", 384'(tx_data), 384'(8'hA0));
    check("reset_job_valid", 384'(job_valid), 384'(1'b0));
    check("reset_err", 384'(err_flag), 384'(1'b0));
    check("reset_job_state", 384'(job_state), 384'(0));

    send(8'hA3);
    check("status_idle", 384'(tx_data), 384'(8'hA0));
    core_busy = 1'b1;
    send(8'hA3);
    check("status_busy", 384'(tx_data), 384'(8'hA1));
    core_busy = 1'b0;

    load_job(8'h00, 1'b0);
    b8 = job_state[SB*8-1 -: 8];
    check("load_state_msb", 384'(b8), 384'(8'h00));
    b8 = job_state[7:0];
    check("load_state_lsb", 384'(b8), 384'(8'h1F));
    msg_lit = 96'h202122232425262728292A2B;
    check("load_msg", 384'(job_msg), 384'(msg_lit));
    check("load_valid", 384'(job_valid), 384'(1'b1));
    step();
    check("valid_held", 384'(job_valid), 384'(1'b1));
    job_ready = 1'b1; step(); job_ready = 1'b0;
    check("accept_clears", 384'(job_valid), 384'(1'b0));

    for (int pass = 0; pass < 2; pass++) begin
      send(8'hA4);
      check("rd_job_first", 384'(tx_data), 384'(8'h00));
      for (int k = 1; k <= JOB; k++) begin
        send(8'hFF);
        if (k < JOB) check("rd_job_byte", 384'(tx_data), 384'(8'(k)));
        else check("rd_job_end", 384'(tx_data), 384'(8'hA0));
      end
    end

    res_valid = 1'b1; res_data = 32'hDEADBEEF; step(); res_valid = 1'b0;
    send(8'hA3);
    check("status_res", 384'(tx_data), 384'(8'hA6));
    send(8'hA5);
    check("res_b0", 384'(tx_data), 384'(8'hDE));
    send(8'h00); check("res_b1", 384'(tx_data), 384'(8'hAD));
    send(8'h00); check("res_b2", 384'(tx_data), 384'(8'hBE));
    send(8'h00); check("res_b3", 384'(tx_data), 384'(8'hEF));
    send(8'h00); check("res_end", 384'(tx_data), 384'(8'hA0));
    send(8'hA3);
    check("status_after_res", 384'(tx_data), 384'(8'hA0));

    res_valid = 1'b1; res_data = 32'hCAFEF00D; step(); res_valid = 1'b0;
    send(8'hA5);
    send(8'h00);
    res_valid = 1'b1; res_data = 32'h12345678; step(); res_valid = 1'b0;
    send(8'h00); check("hold_b2", 384'(tx_data), 384'(8'hF0));
    send(8'h00); check("hold_b3", 384'(tx_data), 384'(8'h0D));
    send(8'h00);
    send(8'hA3);
    check("hold_pending", 384'(tx_data), 384'(8'hA6));
    send(8'hA5);
    check("hold_new_b0", 384'(tx_data), 384'(8'h12));
    repeat (RB) send(8'h00);

    load_job(8'h80, 1'b0);
    load_job(8'h40, 1'b1);
    check("simul_valid", 384'(job_valid), 384'(1'b1));
    b8 = job_state[SB*8-1 -: 8];
    check("simul_new_data", 384'(b8), 384'(8'h40));
    job_ready = 1'b1; step(); job_ready = 1'b0;

    send(8'h55);
    check("unknown_err", 384'(err_flag), 384'(1'b1));
    check("unknown_tx", 384'(tx_data), 384'(8'hA0));

    load_job(8'h10, 1'b0);
    send(8'hA2);
    for (int i = 0; i < 10; i++) send(8'(8'h60 + i));
    apply_reset();
    check("rst_mid_valid", 384'(job_valid), 384'(1'b0));
    check("rst_mid_state", 384'(job_state), 384'(0));
    send(8'hA3);
    check("rst_mid_status", 384'(tx_data), 384'(8'hA0));

`ifdef MINER_CMD_CHECKSUM_EN
    send(8'hA2);
    for (int i = 0; i < JOB; i++) send(8'(i));
    send(8'h77);
    check("csum_bad_err", 384'(err_flag), 384'(1'b1));
    check("csum_bad_nocommit", 384'(job_valid), 384'(1'b0));
`endif

    load_job(8'h20, 1'b0);
    b8 = job_state[SB*8-1 -: 8];
    check("reload_after_reset", 384'(b8), 384'(8'h20));
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/miner_cmd_frontend.md
Name: miner_cmd_frontend

Overview:
Byte-level command front end for the miner. It sits between the SPI slave byte interface and the hashing core. It decodes host commands, assembles a job (previous hash state plus message tail) of parametrised width, and hands that job to the core with a valid/ready handshake. It also returns status, the loaded job (read back without destroying it) and the core's nonce result.

Parameters:
STATE_BYTES, 32, bytes of previous hash state per job (1..64)
MSG_BYTES, 12, bytes of message tail per job (1..64)
RES_BYTES, 4, bytes of result nonce (1..8)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_valid  in  1  one-cycle pulse: byte received from SPI slave
rx_data  in  8  received byte, valid with rx_valid
tx_data  out  8  byte the SPI slave shifts out on the next transfer
job_state  out  STATE_BYTES*8  loaded state; first received byte in the MSBs
job_msg  out  MSG_BYTES*8  loaded message tail; first received byte in the MSBs
job_valid  out  1  job pending for the core
job_ready  in  1  core accepts the job (handshake completes when job_valid && job_ready)
core_busy  in  1  core is hashing
res_valid  in  1  one-cycle pulse: core found a result
res_data  in  RES_BYTES*8  result nonce, valid with res_valid
err_flag  out  1  sticky: an unknown command was received, or (optional feature) a checksum failed

Behaviour:
- Command codes: MSG_START=A2, GET_STATE=A3, GET_MSG=A4, GET_RES=A5. Status bytes: WAITING=A0, WORKING=A1, RES_READY=A6.
- Reset (async) values: tx_data=A0; job_state=0; job_msg=0; job_valid=0; err_flag=0; result buffer=0; res_pending=0; FSM=IDLE; byte counter=0.
- All state changes happen on posedge clk. Only cycles with rx_valid=1 advance the FSM. tx_data is registered and takes its new value in the same cycle the byte is consumed.
- FSM states and transitions:
  - IDLE, byte A2: go to LOAD, cnt=0.
  - IDLE, byte A3: tx_data = A6 if res_pending, else A1 if core_busy, else A0.
  - IDLE, byte A4: go to RD_JOB, cnt=0, tx_data = byte 0 of the job.
  - IDLE, byte A5: go to RD_RES, cnt=0, tx_data = result byte 0 (MSB).
  - IDLE, any other byte: set err_flag, tx_data=A0.
  - LOAD: byte cnt goes to the shadow buffer (state bytes cnt<STATE_BYTES, then message bytes). cnt increments.
  - LOAD, cnt == STATE_BYTES+MSG_BYTES-1: the shadow buffer is copied to job_state/job_msg on the next edge, job_valid=1, FSM returns to IDLE, tx_data=A0.
  - RD_JOB: each byte received (content ignored) sets tx_data = job byte cnt+1. The read is non-destructive: it indexes a mux and does not shift the job registers.
  - RD_JOB, last job byte sent (cnt == STATE_BYTES+MSG_BYTES-1): tx_data=A0, FSM returns to IDLE.
  - RD_RES: same indexing scheme over RES_BYTES. On exit, res_pending clears.
- Handshake: job_valid stays at 1 until a cycle with job_valid && job_ready; on the next edge it clears.
  - A new load completing while job_valid=1 overwrites the job; job_valid stays 1.
  - If completion and acceptance fall on the same cycle, the new job wins: job_valid stays 1.
  - job_state/job_msg are stable while job_valid=1, except when a load completes.
- Result: res_valid captures res_data and sets res_pending.
  - A res_valid during RD_RES is held off until RD_RES exits, so the read stays coherent.
  - The capture then occurs, and res_pending stays 1.
- Counter width is $clog2(STATE_BYTES+MSG_BYTES+1). No wrap: every payload state exits exactly on its final byte.
- A reset mid-load discards the partial shadow buffer. Registers already committed to job_state/job_msg also reset to 0.

Optional Feature:
- Macro: MINER_CMD_CHECKSUM_EN.
- Defined: LOAD expects one extra byte after the payload, equal to the XOR of all payload bytes.
  - Match: commit as above.
  - Mismatch: no commit, job_valid unchanged, err_flag=1, tx_data=A0.
- Undefined: no checksum byte is expected; commit happens on the last payload byte.

Test Plan:
- Reset, then host sends A3 with core_busy=0 -> next tx_data=A0. With core_busy=1, A3 -> A1.
- Load with defaults: A2, state bytes 00..1F, msg bytes 20..2B -> job_state MSB byte=00, LSB byte=1F; job_msg=202122..2B; job_valid=1. job_ready=1 for 1 cycle -> job_valid=0.
- Readback: send A4 then 44 dummy bytes -> tx_data sequence 00..2B then A0. Send A4 again -> identical sequence (non-destructive).
- Result: res_valid with res_data=DEADBEEF -> A3 returns A6. A5 plus 4 dummies -> DE, AD, BE, EF, A0. A3 afterwards -> A0.
- Simultaneous: job_valid=1 and job_ready=1 on the same cycle as the final load byte -> job_valid stays 1 with the new data. Unknown byte 55 in IDLE -> err_flag=1.
- Reset asserted after 10 load bytes, then released -> FSM=IDLE, job_valid=0. A following A3 -> A0. With MINER_CMD_CHECKSUM_EN, a bad checksum -> no commit, err_flag=1.
